seg_display_arbiter: RTL and testbench
======================================

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: minimum display hold per grant, in clk cycles (>=2).
REQ-002 Parameter BLINK_HALF, default 25_000_000: blink half-period, in clk cycles (>=1).
REQ-003 clk  input  1  system clock; all state SHALL change only on its rising edge, except on reset.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req  input  3  per-port display request, level; port 0 = alert, port 1 = game, port 2 = timer.
REQ-006 req_data  input  96  per-port 32-bit hex digit word; port i uses bits [32i+31:32i].
REQ-007 req_valid  input  24  per-port 8-bit digit-enable mask; port i uses bits [8i+7:8i].
REQ-008 blink  input  3  per-port blink request, sampled at grant.
REQ-009 output_data  output  32  registered digit word for the segment scanner.
REQ-010 output_valid  output  8  registered digit-enable mask for the segment scanner.
REQ-011 grant  output  3  one-hot owner of the display; 0 when blank.
REQ-012 ack  output  3  one-cycle pulse to a port on each new grant to it.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE (blank), SHOW (owner req high, live data), LINGER (owner req dropped, frozen data).
REQ-015 Arbitration: port 0 SHALL have strict priority; ports 1 and 2 SHALL be round-robin, favouring the port not most recently granted of the two (pointer resets to favour port 1).
REQ-016 IDLE: any req sampled high SHALL, on the next edge, enter SHOW, set grant to the winner, pulse ack, load the winner's data and mask, and load the hold counter to HOLD_CYCLES-1.
REQ-017 In SHOW, output_data and output_valid SHALL follow the owner's req_data and req_valid with one-cycle latency.
REQ-018 In SHOW, an owner req drop SHALL move the FSM to LINGER with outputs frozen at their last registered values.
REQ-019 The hold counter SHALL decrement once per cycle in SHOW and LINGER, and saturate at 0.
REQ-020 SHOW at count 0: if another port wins arbitration, the FSM SHALL switch to it (ack pulse, counter reload); otherwise it SHALL stay with the owner, reload the counter and issue no ack.
REQ-021 LINGER at count 0: the FSM SHALL arbitrate across all req (owner included) and enter SHOW; with no req it SHALL enter IDLE, with grant=0 and outputs 0.
REQ-022 Preemption: req[0] high while port 1 or 2 owns the display, in SHOW or LINGER, SHALL grant port 0 on the next edge regardless of the counter.
REQ-023 An owner that re-raises req in LINGER SHALL wait for counter expiry; there is no early return to SHOW.
REQ-024 Owner req drop on the same cycle the count reaches 0 SHALL be handled as LINGER expiry, i.e. immediate arbitration.
REQ-025 Data-path width rules: no digit or mask manipulation; words SHALL pass bit-exact.

Reset
REQ-026 While rst is low, the FSM SHALL be IDLE, and output_data, output_valid, grant, ack and busy SHALL be 0.
REQ-027 While rst is low, the hold counter, blink counter and phase SHALL be 0, and the round-robin pointer SHALL favour port 1.
REQ-028 Reset asserted mid-grant SHALL blank the outputs immediately (asynchronously); no ack SHALL be issued for the aborted grant.

Configuration
REQ-029 Macro SEG_DISPLAY_BLINK_EN defined: the blink bit of the winner SHALL be latched at each grant.
REQ-030 With SEG_DISPLAY_BLINK_EN defined and the latched bit set, output_valid SHALL be forced to 0 during alternate BLINK_HALF-cycle phases.
REQ-031 With SEG_DISPLAY_BLINK_EN defined, each grant SHALL start the blink phase "on" with its counter at 0.
REQ-032 Macro SEG_DISPLAY_BLINK_EN undefined: the blink input SHALL be ignored, no blink counter SHALL be built, and output_valid SHALL never be gated.

Verification (HOLD_CYCLES=4, BLINK_HALF=2)
REQ-033 Reset, then req=3'b010 with port1 data 32'h0000_1234 and mask 8'h0F -> next cycle grant=010, ack=010 for 1 cycle, output_data=32'h1234, output_valid=8'h0F, busy=1.
REQ-034 req=3'b110 held -> grants alternate port1/port2 every 4 cycles, with an ack on each switch.
REQ-035 Port 2 owning, req[0] rises at hold count 2 -> next cycle grant=001 with port 0 data.
REQ-036 Port 1 req drops 1 cycle after grant -> LINGER, outputs frozen for 3 more cycles, then IDLE with grant=0, outputs 0, busy=0.
REQ-037 SEG_DISPLAY_BLINK_EN defined, port 1 granted with blink[1]=1 and mask 8'hFF -> output_valid sequence FF,FF,00,00,FF,...
REQ-038 rst low while port 0 owns the display -> outputs 0 before the next edge; after release, req=3'b010 is granted normally.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// ----------------------------------------------------------------------------
// seg_display_arbiter
//
// Purpose:
//   Shares one 8-digit seven-segment display between three requesters
//   (port 0 = alert, port 1 = game, port 2 = timer). The alert port has
//   strict priority and preempts the other two at any time. The game and
//   timer ports take turns round-robin. Every grant keeps the display for
//   at least HOLD_CYCLES clocks. If the owner drops its request early, its
//   last digits stay frozen on the display (LINGER) until the hold expires.
//
// Parameters:
//   HOLD_CYCLES  minimum display hold per grant in clk cycles (>= 2)
//   BLINK_HALF   blink half-period in clk cycles (>= 1)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   req[2:0]      per-port request level
//   req_data[95:0]  per-port 32-bit digit word, port i at [32i+31:32i]
//   req_valid[23:0] per-port 8-bit digit-enable mask, port i at [8i+7:8i]
//   blink[2:0]    per-port blink request, sampled when a grant is made
//   output_data   registered digit word for the segment scanner
//   output_valid  registered digit-enable mask (blink-gated if enabled)
//   grant[2:0]    one-hot display owner, 0 when the display is blank
//   ack[2:0]      one-cycle pulse to a port on each new grant to it
//   busy          high whenever the FSM is not IDLE
//
// Build option:
//   SEG_DISPLAY_BLINK_EN  when defined, the winner's blink bit is latched at
//                         each grant. While that bit is set, output_valid is
//                         blanked on alternate BLINK_HALF-cycle phases. When
//                         the macro is undefined, blink is ignored and no
//                         blink counter exists.
// ----------------------------------------------------------------------------
module seg_display_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_HALF  = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [95:0] req_data,
    input  logic [23:0] req_valid,
    input  logic [2:0]  blink,
    output logic [31:0] output_data,
    output logic [7:0]  output_valid,
    output logic [2:0]  grant,
    output logic [2:0]  ack,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHOW   = 2'd1;
    localparam logic [1:0] ST_LINGER = 2'd2;

    localparam int                CNT_W     = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       ack_q, ack_d;
    logic [31:0]      data_q, data_d;
    logic [7:0]       valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // 0: the next port 1 / port 2 tie goes to port 1. 1: it goes to port 2.
    logic             rr_q, rr_d;

    logic [2:0] win;       // arbitration result over all current requests
    logic [2:0] take_oh;   // non-zero: a new grant to this port at the edge
    logic       blank;     // return to IDLE with a cleared display
    logic       owner_req;
    logic       preempt;

    function automatic logic [31:0] pick_data(input logic [2:0] oh, input logic [95:0] d);
        pick_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (oh[i]) pick_data = d[32*i +: 32];
        end
    endfunction

    function automatic logic [7:0] pick_valid(input logic [2:0] oh, input logic [23:0] v);
        pick_valid = '0;
        for (int i = 0; i < 3; i++) begin
            if (oh[i]) pick_valid = v[8*i +: 8];
        end
    endfunction

    // Alert first, then the round-robin pair.
    always_comb begin
        win = 3'b000;
        if (req[0])                win = 3'b001;
        else if (req[1] && req[2]) win = rr_q ? 3'b100 : 3'b010;
        else if (req[1])           win = 3'b010;
        else if (req[2])           win = 3'b100;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = 3'b000;
        data_d    = data_q;
        valid_d   = valid_q;
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        rr_d      = rr_q;
        take_oh   = 3'b000;
        blank     = 1'b0;
        owner_req = |(req & grant_q);
        // The alert port cuts in on the other two regardless of the hold count.
        preempt   = req[0] && (grant_q[1] || grant_q[2]);

        case (state_q)
            ST_IDLE: begin
                if (|req) take_oh = win;
            end
            ST_SHOW: begin
                if (preempt) begin
                    take_oh = 3'b001;
                end else if (!owner_req) begin
                    // If the drop coincides with expiry, arbitrate at once
                    // rather than spending a cycle in LINGER.
                    if (cnt_q == '0) begin
                        if (|req) take_oh = win;
                        else      blank   = 1'b1;
                    end else begin
                        state_d = ST_LINGER;
                    end
                end else if (cnt_q == '0 && win != grant_q) begin
                    take_oh = win;
                end else begin
                    // The owner keeps the display. Its live data follows,
                    // and the hold restarts silently at expiry.
                    data_d  = pick_data(grant_q, req_data);
                    valid_d = pick_valid(grant_q, req_valid);
                    if (cnt_q == '0) cnt_d = HOLD_LOAD;
                end
            end
            ST_LINGER: begin
                // Data stays frozen. A re-raised owner request only counts
                // once the hold has expired.
                if (preempt) begin
                    take_oh = 3'b001;
                end else if (cnt_q == '0) begin
                    if (|req) take_oh = win;
                    else      blank   = 1'b1;
                end
            end
            default: blank = 1'b1;
        endcase

        if (blank) begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            data_d  = '0;
            valid_d = '0;
            cnt_d   = '0;
        end

        if (|take_oh) begin
            state_d = ST_SHOW;
            grant_d = take_oh;
            ack_d   = take_oh;
            data_d  = pick_data(take_oh, req_data);
            valid_d = pick_valid(take_oh, req_valid);
            cnt_d   = HOLD_LOAD;
            if (take_oh[1])      rr_d = 1'b1;
            else if (take_oh[2]) rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            ack_q   <= 3'b000;
            data_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign output_data = data_q;
    assign grant       = grant_q;
    assign ack         = ack_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef SEG_DISPLAY_BLINK_EN
    localparam int             BW         = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic          blink_en_q, blink_en_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;    // 0 = digits shown, 1 = digits blanked

    always_comb begin
        blink_en_d = blink_en_q;
        bcnt_d     = bcnt_q;
        phase_d    = phase_q;
        if (|take_oh) begin
            // Every new grant starts in the visible phase.
            blink_en_d = |(take_oh & blink);
            bcnt_d     = '0;
            phase_d    = 1'b0;
        end else if (state_d == ST_IDLE) begin
            blink_en_d = 1'b0;
            bcnt_d     = '0;
            phase_d    = 1'b0;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_en_q <= 1'b0;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
        end else begin
            blink_en_q <= blink_en_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
        end
    end

    assign output_valid = valid_q & {8{~(blink_en_q & phase_q)}};
`else
    logic unused_blink;
    assign unused_blink = ^blink;
    assign output_valid = valid_q;
`endif

endmodule

// File: tb/tb_seg_display_arbiter.sv
// ----------------------------------------------------------------------------
// tb_seg_display_arbiter
//
// Scoreboard bench for seg_display_arbiter with HOLD_CYCLES=4, BLINK_HALF=2.
// The driver applies one stimulus set per cycle on the falling edge and
// pushes the outputs expected after the following rising edge. A monitor
// pops and compares 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_seg_display_arbiter;

    localparam logic [31:0] D0  = 32'hAAAA_5555;
    localparam logic [31:0] D1  = 32'h0000_1234;
    localparam logic [31:0] D1B = 32'h0000_4321;
    localparam logic [31:0] D1X = 32'hDEAD_BEEF;
    localparam logic [31:0] D2  = 32'h8765_4321;
    localparam logic [7:0]  V0  = 8'hF0;
    localparam logic [7:0]  V1  = 8'h0F;
    localparam logic [7:0]  V2  = 8'h3C;
`ifdef SEG_DISPLAY_BLINK_EN
    localparam logic [7:0]  BOFF = 8'h00;
`else
    localparam logic [7:0]  BOFF = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] req_data;
    logic [23:0] req_valid;
    logic [2:0]  blink;
    logic [31:0] output_data;
    logic [7:0]  output_valid;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic        busy;

    logic [31:0] pd [3];
    logic [7:0]  pv [3];
    logic [2:0]  bl;

    typedef struct packed {
        logic [2:0]  g;
        logic [2:0]  a;
        logic [31:0] d;
        logic [7:0]  v;
        logic        b;
    } exp_t;

    exp_t  sb [$];
    string tag_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    seg_display_arbiter #(
        .HOLD_CYCLES(4),
        .BLINK_HALF (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .blink       (blink),
        .output_data (output_data),
        .output_valid(output_valid),
        .grant       (grant),
        .ack         (ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] r,
                        input logic [2:0] eg, input logic [2:0] ea,
                        input logic [31:0] ed, input logic [7:0] ev, input logic eb);
        exp_t e;
        @(negedge clk);
        req       = r;
        req_data  = {pd[2], pd[1], pd[0]};
        req_valid = {pv[2], pv[1], pv[0]};
        blink     = bl;
        e.g = eg; e.a = ea; e.d = ed; e.v = ev; e.b = eb;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_blank(input string tag);
        check_eq({tag, ".grant"}, grant, 3'b000);
        check_eq({tag, ".ack"},   ack,   3'b000);
        check_eq({tag, ".data"},  output_data,  32'h0);
        check_eq({tag, ".valid"}, output_valid, 8'h00);
        check_eq({tag, ".busy"},  busy,  1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        req = 3'b000;
        repeat (2) @(negedge clk);
        check_blank(tag);
        rst = 1'b1;
    endtask

    // Monitor: one line per transaction
    always @(posedge clk) begin
        exp_t  e;
        string t;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            t = tag_q.pop_front();
            $display("[TB] %s grant=%b ack=%b data=%h valid=%h busy=%b",
                     t, grant, ack, output_data, output_valid, busy);
            check_eq({t, ".grant"}, grant, e.g);
            check_eq({t, ".ack"},   ack,   e.a);
            check_eq({t, ".data"},  output_data,  e.d);
            check_eq({t, ".valid"}, output_valid, e.v);
            check_eq({t, ".busy"},  busy,  e.b);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = 3'b000; blink = 3'b000; bl = 3'b000;
        pd[0] = D0; pd[1] = D1; pd[2] = D2;
        pv[0] = V0; pv[1] = V1; pv[2] = V2;
        req_data  = {pd[2], pd[1], pd[0]};
        req_valid = {pv[2], pv[1], pv[0]};
        repeat (3) @(negedge clk);
        check_blank("rst0");
        rst = 1'b1;

        // First grant, early drop, frozen LINGER, then blank
        step("A.idle", 3'b000, 3'b000, 3'b000, 32'h0, 8'h00, 1'b0);
        step("A.grant", 3'b010, 3'b010, 3'b010, D1, V1, 1'b1);
        pd[1] = D1X;
        step("A.ling1", 3'b000, 3'b010, 3'b000, D1, V1, 1'b1);
        step("A.ling2", 3'b000, 3'b010, 3'b000, D1, V1, 1'b1);
        step("A.ling3", 3'b000, 3'b010, 3'b000, D1, V1, 1'b1);
        step("A.blank", 3'b000, 3'b000, 3'b000, 32'h0, 8'h00, 1'b0);
        pd[1] = D1;

        // Round-robin between ports 1 and 2, live data follow
        do_reset("rstB");
        step("B.g1", 3'b110, 3'b010, 3'b010, D1, V1, 1'b1);
        pd[1] = D1B;
        step("B.fol", 3'b110, 3'b010, 3'b000, D1B, V1, 1'b1);
        pd[1] = D1;
        step("B.h1a", 3'b110, 3'b010, 3'b000, D1, V1, 1'b1);
        step("B.h1b", 3'b110, 3'b010, 3'b000, D1, V1, 1'b1);
        step("B.g2", 3'b110, 3'b100, 3'b100, D2, V2, 1'b1);
        for (int i = 0; i < 3; i++)
            step("B.h2", 3'b110, 3'b100, 3'b000, D2, V2, 1'b1);
        step("B.g1b", 3'b110, 3'b010, 3'b010, D1, V1, 1'b1);
        for (int i = 0; i < 3; i++)
            step("B.h1", 3'b110, 3'b010, 3'b000, D1, V1, 1'b1);
        step("B.g2b", 3'b110, 3'b100, 3'b100, D2, V2, 1'b1);
        step("B.h2c", 3'b110, 3'b100, 3'b000, D2, V2, 1'b1);

        // Alert preemption at hold count 2, then owner kept at expiry
        step("C.pre", 3'b111, 3'b001, 3'b001, D0, V0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("C.h0", 3'b111, 3'b001, 3'b000, D0, V0, 1'b1);
        step("C.stay", 3'b111, 3'b001, 3'b000, D0, V0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("C.ling", 3'b110, 3'b001, 3'b000, D0, V0, 1'b1);
        step("C.rr", 3'b110, 3'b010, 3'b010, D1, V1, 1'b1);
        for (int i = 0; i < 3; i++)
            step("C.h1", 3'b110, 3'b010, 3'b000, D1, V1, 1'b1);
        // Owner drop exactly at expiry arbitrates immediately
        step("C.dropz", 3'b100, 3'b100, 3'b100, D2, V2, 1'b1);
        // Owner re-raise in LINGER waits for expiry
        step("C.l1", 3'b000, 3'b100, 3'b000, D2, V2, 1'b1);
        step("C.re1", 3'b100, 3'b100, 3'b000, D2, V2, 1'b1);
        step("C.re2", 3'b100, 3'b100, 3'b000, D2, V2, 1'b1);
        step("C.reg", 3'b100, 3'b100, 3'b100, D2, V2, 1'b1);
        // Alert preempts a lingering port
        step("C.l2", 3'b000, 3'b100, 3'b000, D2, V2, 1'b1);
        step("C.lpre", 3'b001, 3'b001, 3'b001, D0, V0, 1'b1);

        // Blink (gated only when the option is built in)
        do_reset("rstD");
        pv[1] = 8'hFF;
        bl    = 3'b010;
        step("D.b1", 3'b010, 3'b010, 3'b010, D1, 8'hFF, 1'b1);
        step("D.b2", 3'b010, 3'b010, 3'b000, D1, 8'hFF, 1'b1);
        step("D.b3", 3'b010, 3'b010, 3'b000, D1, BOFF,  1'b1);
        step("D.b4", 3'b010, 3'b010, 3'b000, D1, BOFF,  1'b1);
        step("D.b5", 3'b010, 3'b010, 3'b000, D1, 8'hFF, 1'b1);
        step("D.b6", 3'b010, 3'b010, 3'b000, D1, 8'hFF, 1'b1);
        pv[1] = V1;
        bl    = 3'b000;

        // Asynchronous reset in the middle of an alert grant
        do_reset("rstE");
        step("E.g0", 3'b001, 3'b001, 3'b001, D0, V0, 1'b1);
        step("E.h0", 3'b001, 3'b001, 3'b000, D0, V0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_blank("E.async");
        req = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step("E.after", 3'b010, 3'b010, 3'b010, D1, V1, 1'b1);
        step("E.after2", 3'b010, 3'b010, 3'b000, D1, V1, 1'b1);

        repeat (3) @(negedge clk);
        check_eq("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
